// File: rtl/mips_multicycle_sequencer_pkg.sv
// Shared opcode constants, sequencer states and
// helpers for the multi-cycle MIPS sequencer.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALTED
  } state_t;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

  // Opcodes that execute (halt is checked separately).
  function automatic logic is_known(
    input logic [5:0] op
  );
    return op inside {OP_RTYPE, OP_ADDI, OP_LW,
                      OP_SW, OP_BEQ, OP_J};
  endfunction

endpackage

// File: rtl/mips_multicycle_sequencer_if.sv
// ALU bus between the sequencer (master) and
// the ALU top (slave).
interface mips_multicycle_sequencer_if;

  logic [5:0]  alu_opcode;
  logic [5:0]  alu_func;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  modport master (
    output alu_opcode, alu_func, alu_a, alu_b,
    input  alu_result, alu_zero
  );

  modport slave (
    input  alu_opcode, alu_func, alu_a, alu_b,
    output alu_result, alu_zero
  );

endinterface

// File: rtl/mips_multicycle_sequencer_fsm.sv
// Sequencer state machine: state register, next
// state and registered per-state strobes.
module mips_seq_fsm
  import mips_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic [5:0] opcode,
  output state_t     state,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       wb_en,
  output logic       ex_en,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);

  state_t nxt;
  logic   ill_nxt;

  // Next state from the current state and opcode.
  always_comb begin
    nxt     = state;
    ill_nxt = 1'b0;
    unique case (state)
      IDLE:   if (start) nxt = FETCH;
      FETCH:  if (imem_ready) nxt = DECODE;
      DECODE: begin
        if (opcode == OP_J) begin
          nxt = FETCH;
        end else if (opcode == HALT_OPCODE) begin
          nxt = HALTED;
        end else if (!is_known(opcode)) begin
          nxt     = HALTED;
          ill_nxt = 1'b1;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        if (opcode == OP_BEQ)
          nxt = FETCH;
        else if (opcode == OP_LW || opcode == OP_SW)
          nxt = MEM;
        else
          nxt = WB;
      end
      MEM: begin
        if (dmem_ready)
          nxt = (opcode == OP_LW) ? WB : FETCH;
      end
      WB:     nxt = FETCH;
      HALTED: nxt = HALTED;
      default: nxt = IDLE;
    endcase
  end

  // State and strobes registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      wb_en    <= 1'b0;
      ex_en    <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= nxt;
      imem_req <= (nxt == FETCH);
      dmem_req <= (nxt == MEM);
      wb_en    <= (nxt == WB);
      ex_en    <= (nxt == EXEC);
      busy     <= (nxt != IDLE) && (nxt != HALTED);
      halted   <= (nxt == HALTED);
      if (ill_nxt) illegal <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle MIPS sequencer: PC/IR/A/B/ALUOut/MDR
// datapath around the mips_seq_fsm controller.
module mips_multicycle_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  mips_multicycle_sequencer_if.master alu,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  logic [31:0] ir, a, b, alu_out, mdr, imm;
  logic [5:0]  op;
  logic [4:0]  wb_addr;
  logic        wb_en, ex_en;
  logic        is_r, is_lw, is_sw, is_beq, is_j;
  state_t      state;

  assign op     = ir[31:26];
  assign imm    = sext16(ir[15:0]);
  assign is_r   = (op == OP_RTYPE);
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_beq = (op == OP_BEQ);
  assign is_j   = (op == OP_J);

  mips_seq_fsm #(
    .HALT_OPCODE(HALT_OPCODE)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .opcode    (op),
    .state     (state),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .wb_en     (wb_en),
    .ex_en     (ex_en),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal)
  );

  // Datapath registers, each loaded in its own state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      if (imem_req && imem_ready) begin
        ir <= imem_rdata;
        pc <= pc + 32'd4;
      end
      if (state == DECODE) begin
        a <= rf_rdata1;
        b <= rf_rdata2;
        if (is_j)
          pc <= {pc[31:28], ir[25:0], 2'b00};
      end
      if (ex_en) begin
        alu_out <= alu.alu_result;
        if (is_beq && alu.alu_zero)
          pc <= pc + {imm[29:0], 2'b00};
      end
      if (dmem_req && dmem_ready && is_lw)
        mdr <= dmem_rdata;
    end
  end

  assign imem_addr = imem_req ? pc : '0;
  assign rf_raddr1 = ir[25:21];
  assign rf_raddr2 = ir[20:16];

  assign wb_addr  = is_r ? ir[15:11] : ir[20:16];
  assign rf_waddr = wb_en ? wb_addr : '0;
  assign rf_wdata = !wb_en ? '0 :
                    is_lw  ? mdr : alu_out;
  assign rf_we    = wb_en && (wb_addr != 5'd0);

  assign alu.alu_opcode = ex_en ? op : '0;
  assign alu.alu_func   = ex_en ? ir[5:0] : '0;
  assign alu.alu_a      = ex_en ? a : '0;
  assign alu.alu_b      = !ex_en        ? '0 :
                          (is_r||is_beq) ? b : imm;

  assign dmem_we    = dmem_req && is_sw;
  assign dmem_addr  = dmem_req ? alu_out : '0;
  assign dmem_wdata = dmem_req ? b : '0;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Directed vector bench for the multi-cycle sequencer
// with behavioural imem, dmem, register file and ALU.
module tb_mips_multicycle_sequencer;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        clr = 0;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc;
  logic        busy, halted, illegal;

  mips_multicycle_sequencer_if alu_bus();

  mips_multicycle_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .alu       (alu_bus),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // imem: four programmable words, halt elsewhere
  logic [31:0] ia [4];
  logic [31:0] id [4];
  int idelay = 0, ddelay = 0;
  int icnt, dcnt;

  always_comb begin
    imem_rdata = 32'hFC00_0000;
    for (int i = 0; i < 4; i++)
      if (ia[i] == imem_addr) imem_rdata = id[i];
  end

  assign imem_ready = imem_req && (icnt == idelay);
  assign dmem_ready = dmem_req && (dcnt == ddelay);
  assign dmem_rdata = (dmem_req && !dmem_we) ?
                      {dmem_addr[15:0], 16'hBEEF} : 32'h0;

  // ready delay counters
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (!imem_req || imem_ready) ? 0 : icnt + 1;
      dcnt <= (!dmem_req || dmem_ready) ? 0 : dcnt + 1;
    end
  end

  // register file
  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  function automatic logic [31:0] preset(input int i);
    case (i)
      1:  return 32'h55;
      2:  return 32'h66;
      3:  return 32'h100;
      5:  return 32'hDEAD;
      9:  return 32'd5;
      10: return 32'd7;
      default: return 32'h0;
    endcase
  endfunction

  // ALU reference model
  logic [31:0] ares;
  always_comb begin
    ares = 32'h0;
    case (alu_bus.alu_opcode)
      6'h00: begin
        if (alu_bus.alu_func == 6'h20)
          ares = alu_bus.alu_a + alu_bus.alu_b;
        else if (alu_bus.alu_func == 6'h22)
          ares = alu_bus.alu_a - alu_bus.alu_b;
      end
      6'h08, 6'h23, 6'h2B:
        ares = alu_bus.alu_a + alu_bus.alu_b;
      6'h04:
        ares = alu_bus.alu_a - alu_bus.alu_b;
      default: ares = 32'h0;
    endcase
  end
  assign alu_bus.alu_result = ares;
  assign alu_bus.alu_zero   = (ares == 32'h0);

  // observation: writes, accesses, fetches, cycles
  int nwr, ndm, nbusy, nf, nireq, ndreq;
  logic [4:0]  lwa;
  logic [31:0] lwd, lda, ldw;
  logic        ldwe;
  logic [31:0] fa [8];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= preset(i);
      nwr <= 0; ndm <= 0; nbusy <= 0;
      nf <= 0; nireq <= 0; ndreq <= 0;
    end else if (!rst) begin
      if (rf_we) begin
        rf[rf_waddr] <= rf_wdata;
        nwr <= nwr + 1;
        lwa <= rf_waddr;
        lwd <= rf_wdata;
      end
      if (dmem_req && dmem_ready) begin
        ndm  <= ndm + 1;
        lda  <= dmem_addr;
        ldw  <= dmem_wdata;
        ldwe <= dmem_we;
      end
      if (imem_req && imem_ready) begin
        if (nf < 8) fa[nf] <= imem_addr;
        nf <= nf + 1;
      end
      if (busy) nbusy <= nbusy + 1;
      if (imem_req) nireq <= nireq + 1;
      if (dmem_req) ndreq <= ndreq + 1;
    end
  end

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h",
               nm, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] w0);
    for (int i = 0; i < 4; i++) begin
      ia[i] = 32'h1;
      id[i] = 32'h0;
    end
    ia[0] = 32'h0;
    id[0] = w0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1; clr = 1; start = 0;
    @(negedge clk);
    clr = 0; rst = 0;
  endtask

  task automatic run(input int budget);
    int n = 0;
    do_reset;
    start = 1;
    @(negedge clk);
    start = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("run_halted", {31'h0, halted}, 32'h1);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] instr;
    int          cyc;
    logic [31:0] fpc;
    int          wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          dm;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dw;
    logic        ill;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{"add",  32'h012A_4020, 6, 32'h8,
              1, 5'd8, 32'd12, 0, 0, 0, 0, 0};
    vt[1] = '{"beq_t", 32'h1021_0003, 5, 32'h14,
              0, 0, 0, 0, 0, 0, 0, 0};
    vt[2] = '{"beq_n", 32'h1022_0003, 5, 32'h8,
              0, 0, 0, 0, 0, 0, 0, 0};
    vt[3] = '{"lw",   32'h8C62_FFFC, 7, 32'h8,
              1, 5'd2, 32'h00FC_BEEF,
              1, 0, 32'hFC, 32'h66, 0};
    vt[4] = '{"addi0", 32'h2000_0009, 6, 32'h8,
              0, 0, 0, 0, 0, 0, 0, 0};
    vt[5] = '{"sw",   32'hAC05_0008, 6, 32'h8,
              0, 0, 0, 1, 1, 32'h8, 32'hDEAD, 0};
    vt[6] = '{"halt", 32'hFC00_0000, 2, 32'h4,
              0, 0, 0, 0, 0, 0, 0, 0};
    vt[7] = '{"ill",  32'h4400_0000, 2, 32'h4,
              0, 0, 0, 0, 0, 0, 0, 1};
    vt[8] = '{"j",    32'h0800_0010, 4, 32'h44,
              0, 0, 0, 0, 0, 0, 0, 0};
    vt[9] = '{"addin", 32'h2127_FFFF, 6, 32'h8,
              1, 5'd7, 32'd4, 0, 0, 0, 0, 0};

    load(32'hFC00_0000);
    do_reset;
    rst = 1;
    #1;
    chk("rst.pc",     pc, 32'h0);
    chk("rst.busy",   {31'h0, busy}, 32'h0);
    chk("rst.halted", {31'h0, halted}, 32'h0);
    chk("rst.ill",    {31'h0, illegal}, 32'h0);
    chk("rst.ireq",   {31'h0, imem_req}, 32'h0);
    chk("rst.iaddr",  imem_addr, 32'h0);
    chk("rst.dreq",   {31'h0, dmem_req}, 32'h0);
    chk("rst.rfwe",   {31'h0, rf_we}, 32'h0);
    chk("rst.aluop",  {26'h0, alu_bus.alu_opcode}, 32'h0);
    chk("rst.alua",   alu_bus.alu_a, 32'h0);
    @(negedge clk);
    rst = 0;

    for (int k = 0; k < 10; k++) begin
      load(vt[k].instr);
      run(40);
      chk({vt[k].nm, ".cyc"}, nbusy, vt[k].cyc);
      chk({vt[k].nm, ".pc"}, pc, vt[k].fpc);
      chk({vt[k].nm, ".nwr"}, nwr, vt[k].wr);
      chk({vt[k].nm, ".ndm"}, ndm, vt[k].dm);
      chk({vt[k].nm, ".ill"}, {31'h0, illegal},
          {31'h0, vt[k].ill});
      chk({vt[k].nm, ".busy"}, {31'h0, busy}, 32'h0);
      if (vt[k].wr > 0) begin
        chk({vt[k].nm, ".wa"}, {27'h0, lwa},
            {27'h0, vt[k].wa});
        chk({vt[k].nm, ".wd"}, lwd, vt[k].wd);
      end
      if (vt[k].dm > 0) begin
        chk({vt[k].nm, ".dwe"}, {31'h0, ldwe},
            {31'h0, vt[k].dwe});
        chk({vt[k].nm, ".da"}, lda, vt[k].da);
        if (vt[k].dwe)
          chk({vt[k].nm, ".dw"}, ldw, vt[k].dw);
      end
    end

    // start is ignored once halted
    start = 1;
    repeat (3) @(negedge clk);
    start = 0;
    chk("hold.halted", {31'h0, halted}, 32'h1);
    chk("hold.ireq", {31'h0, imem_req}, 32'h0);
    chk("hold.pc", pc, 32'h8);

    // lw with both memories three cycles late
    idelay = 3;
    ddelay = 3;
    load(32'h8C62_FFFC);
    run(80);
    chk("lwd.cyc", nbusy, 16);
    chk("lwd.dreq", ndreq, 4);
    chk("lwd.ireq", nireq, 8);
    chk("lwd.da", lda, 32'hFC);
    chk("lwd.dwe", {31'h0, ldwe}, 32'h0);
    chk("lwd.wa", {27'h0, lwa}, 32'd2);
    chk("lwd.wd", lwd, 32'h00FC_BEEF);
    idelay = 0;
    ddelay = 0;

    // PC wraps: 0 -> FFFFFFF8 -> F0000000 -> FFFFFFFC
    load(32'h1021_FFFD);
    ia[1] = 32'hFFFF_FFF8; id[1] = 32'h0800_0000;
    ia[2] = 32'hF000_0000; id[2] = 32'h0BFF_FFFF;
    run(40);
    chk("wrap.nf", nf, 4);
    chk("wrap.f1", fa[1], 32'hFFFF_FFF8);
    chk("wrap.f2", fa[2], 32'hF000_0000);
    chk("wrap.f3", fa[3], 32'hFFFF_FFFC);
    chk("wrap.pc", pc, 32'h0);
    chk("wrap.cyc", nbusy, 9);

    // reset while a store waits on dmem
    ddelay = 10;
    load(32'hAC05_0008);
    do_reset;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int n = 0; n < 20 && !dmem_req; n++)
      @(negedge clk);
    chk("ar.req_seen", {31'h0, dmem_req}, 32'h1);
    rst = 1;
    #1;
    chk("ar.dreq", {31'h0, dmem_req}, 32'h0);
    chk("ar.dwe", {31'h0, dmem_we}, 32'h0);
    chk("ar.pc", pc, 32'h0);
    chk("ar.busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("ar.idle", {30'h0, busy, imem_req}, 32'h0);
    ddelay = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_sequencer.md
Name: mips_multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the basic MIPS processor; it is the initiator side of the ALU interface.
- Fetches an instruction, reads the register file and drives opcode, func and operands into the ALU top.
- Consumes the ALU result and zero flag, then performs data-memory access, register writeback and PC update.
- Holds PC, IR, A/B operand latches and the ALU-out register; memories and the register file are external.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 6'h3F, opcode that stops execution.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching at PC
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= PC)
- imem_rdata  in  32  instruction word
- imem_ready  in  1  imem_rdata valid this cycle
- rf_raddr1  out  5  rs index (IR[25:21])
- rf_raddr2  out  5  rt index (IR[20:16])
- rf_rdata1  in  32  rs data, combinational read
- rf_rdata2  in  32  rt data, combinational read
- rf_we  out  1  register write strobe
- rf_waddr  out  5  destination register
- rf_wdata  out  32  writeback data
- alu_opcode  out  6  to ALU opcode
- alu_func  out  6  to ALU func_field
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_result  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  data address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data
- dmem_ready  in  1  data access complete
- pc  out  32  current PC
- busy  out  1  state not IDLE and not HALTED
- halted  out  1  in HALTED
- illegal  out  1  halted on an unsupported opcode

Behaviour:
- Reset:
  - state IDLE, pc = RESET_PC; IR, A, B and ALUOut cleared.
  - All outputs 0 except pc.
  - Reset mid-transaction aborts it immediately; requests drop asynchronously.
- IDLE:
  - start = 1 moves to FETCH.
  - start is ignored in every other state.
- FETCH:
  - imem_req = 1, imem_addr = pc; held until imem_ready is sampled high.
  - On ready: IR <= imem_rdata, pc <= pc + 4, go to DECODE.
  - imem_ready while imem_req = 0 is ignored.
- DECODE:
  - A <= rf_rdata1, B <= rf_rdata2.
  - Opcode 6'h02 (j): pc <= {pc[31:28], IR[25:0], 2'b00}, go to FETCH.
  - HALT_OPCODE: go to HALTED.
  - Opcode not in {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, HALT_OPCODE}: illegal <= 1, go to HALTED.
  - Otherwise go to EXEC.
- EXEC:
  - alu_opcode = IR[31:26], alu_func = IR[5:0], alu_a = A.
  - alu_b = B for R-type and beq; sign-extended IR[15:0] for addi, lw and sw.
  - ALUOut <= alu_result.
  - beq: if alu_zero, pc <= pc + (sext(IR[15:0]) << 2), with pc already +4; go to FETCH.
  - lw/sw go to MEM; R-type and addi go to WB.
  - alu_* outputs are 0 outside EXEC.
- MEM:
  - dmem_req = 1, dmem_addr = ALUOut, dmem_we = (sw), dmem_wdata = B; held until dmem_ready.
  - sw: go to FETCH.
  - lw: latch dmem_rdata as writeback data, go to WB.
- WB (single cycle):
  - rf_waddr = IR[15:11] for R-type, IR[20:16] for addi/lw.
  - rf_wdata = ALUOut, or the loaded data for lw.
  - rf_we = 1 unless rf_waddr == 0 (writes to $0 suppressed).
  - Go to FETCH.
- HALTED: terminal until rst; halted = 1; pc holds the address after the halt or illegal word.
- Minimum cycles per instruction (memories ready on first request cycle): j 2, beq 3, R/addi 4, sw 4, lw 5.
- Arithmetic: all PC math is 32-bit and wraps modulo 2^32 (pc 32'hFFFF_FFFC + 4 = 0).

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J.
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
  - sign-extend function.
- One natural sub-module, mips_seq_fsm: state register, next-state logic and strobes.
- Datapath registers (PC, IR, A, B, ALUOut, MDR) stay in the top.

Test Plan:
- Reset, then start with imem returning 0x012A4020 (add $8,$9,$10), rf $9 = 5, $10 = 7, ALU model returns 12 -> rf_we pulse with rf_waddr = 8, rf_wdata = 12; pc = 4; 4 cycles from start.
- beq $1,$1,+3 at pc 0, alu_zero = 1 -> next imem_addr = 0x10; with alu_zero = 0 -> next imem_addr = 0x4.
- lw $2, -4($3), $3 = 0x100, imem_ready and dmem_ready delayed 3 cycles each -> dmem_addr = 0xFC, dmem_we = 0, req held until ready; rf_waddr = 2, rf_wdata = dmem_rdata.
- addi $0,$0,9 -> rf_we stays 0 through WB; sw $5,8($0) with $5 = 0xDEAD -> dmem_we = 1, dmem_addr = 8, dmem_wdata = 0xDEAD.
- Instruction 0xFC000000 -> halted = 1, illegal = 0, busy = 0. Opcode 6'h11 -> halted = 1, illegal = 1. start ignored in HALTED.
- rst asserted while dmem_req is pending -> same-cycle dmem_req = 0, pc = RESET_PC, state IDLE. j 0x3FFFFFF from pc 0xF000_0000 -> pc = 0xFFFF_FFFC.
